// File: rtl/snoop_inv_arbiter.sv
// Two-core store-invalidate arbiter: each core queues line addresses of its stores,
// and the arbiter forwards them one at a time as invalidates to the opposite core's dcache.
module snoop_inv_arbiter #(
    parameter int DEPTH         = 4,
    parameter int LINE_OFFSET_W = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      req_valid,
    input  logic [1:0][31:0]                req_addr,
    output logic [1:0]                      req_ready,
    output logic [1:0]                      inv_valid,
    output logic [31:0]                     inv_addr,
    input  logic [1:0]                      inv_ack,
    output logic [1:0][$clog2(DEPTH):0]     pending,
    output logic                            busy
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_grant;
    logic            w_grant_next;
    logic            r_last_grant;
    logic            w_last_grant_next;
    logic [31:0]     r_inv_addr;
    logic [31:0]     w_inv_addr_next;
    logic [1:0]      w_pop;
    logic [1:0]      w_nonempty;
    logic [1:0][31:0] w_head;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_queue
            logic [31:0]    r_mem [DEPTH];
            logic [PTR_W:0] r_wr_ptr;
            logic [PTR_W:0] r_rd_ptr;
            logic [31:0]    r_tail;
            logic [PTR_W:0] w_count;
            logic [31:0]    w_line;
            logic           w_full;
            logic           w_dup;
            logic           w_push;
            logic           w_unused_offset;

            assign w_line          = {req_addr[gi][31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            assign w_unused_offset = &{1'b0, req_addr[gi][LINE_OFFSET_W-1:0]};
            assign w_count         = r_wr_ptr - r_rd_ptr;
            assign w_full          = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
            // r_tail mirrors the newest entry, which stays resident while the queue is non-empty
            // (even if it is the head currently being invalidated).
            assign w_dup           = (w_count != '0) && (r_tail == w_line);
            assign w_push          = req_valid[gi] && !w_full && !w_dup;

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr[PTR_W-1:0]] <= w_line;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_tail   <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_tail   <= w_line;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
            end

            assign req_ready[gi]  = ~w_full;
            assign pending[gi]    = w_count;
            assign w_nonempty[gi] = (w_count != '0);
            assign w_head[gi]     = r_mem[r_rd_ptr[PTR_W-1:0]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_inv_addr   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_inv_addr   <= w_inv_addr_next;
        end
    end

    // The invalidate target is always the core opposite the granted queue.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_inv_addr_next   = r_inv_addr;
        w_pop             = 2'b00;
        inv_valid         = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (|w_nonempty) begin
                    w_grant_next    = (&w_nonempty) ? ~r_last_grant : ~w_nonempty[0];
                    w_inv_addr_next = w_head[w_grant_next];
                    w_state_next    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                inv_valid[~r_grant] = 1'b1;
                if (inv_ack[~r_grant]) begin
                    w_pop[r_grant]    = 1'b1;
                    w_last_grant_next = r_grant;
                    w_state_next      = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign inv_addr = r_inv_addr;
    assign busy     = (r_state != S_IDLE) || (|w_nonempty);

endmodule

// File: tb/tb_snoop_inv_arbiter.sv
// Bench for snoop_inv_arbiter: directed scenarios plus random traffic, all checked
// against a queue-level model of the two invalidation queues and the round-robin grant.
module tb_snoop_inv_arbiter;

    localparam int DEPTH = 4;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0][31:0] req_addr = '0;
    logic [1:0]       req_ready;
    logic [1:0]       inv_valid;
    logic [31:0]      inv_addr;
    logic [1:0]       inv_ack = '0;
    logic [1:0][2:0]  pending;
    logic             busy;

    snoop_inv_arbiter #(.DEPTH(DEPTH), .LINE_OFFSET_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .inv_valid (inv_valid),
        .inv_addr  (inv_addr),
        .inv_ack   (inv_ack),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_steps  = 0;

    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    bit          m_inflight;
    int          m_grant;
    int          m_last_grant;
    logic [31:0] m_inv_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_inflight   = 0;
        m_grant      = 0;
        m_last_grant = 1;
        m_inv_addr   = '0;
    endtask

    // Decisions use the queue contents as they stood before this clock edge.
    task automatic model_update(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [1:0] ack);
        int          s0 = mq0.size();
        int          s1 = mq1.size();
        logic [31:0] l0 = a0 & LINE_MASK;
        logic [31:0] l1 = a1 & LINE_MASK;
        bit          push0 = v[0] && (s0 < DEPTH) && !((s0 > 0) && (mq0[s0-1] == l0));
        bit          push1 = v[1] && (s1 < DEPTH) && !((s1 > 0) && (mq1[s1-1] == l1));
        if (!m_inflight) begin
            if (s0 > 0 || s1 > 0) begin
                if (s0 > 0 && s1 > 0) m_grant = (m_last_grant == 0) ? 1 : 0;
                else                  m_grant = (s0 > 0) ? 0 : 1;
                m_inv_addr = (m_grant == 0) ? mq0[0] : mq1[0];
                m_inflight = 1;
            end
        end else if (ack[1 - m_grant]) begin
            if (m_grant == 0) void'(mq0.pop_front());
            else              void'(mq1.pop_front());
            m_last_grant = m_grant;
            m_inflight   = 0;
        end
        if (push0) mq0.push_back(l0);
        if (push1) mq1.push_back(l1);
    endtask

    task automatic compare_all();
        logic [1:0] exp_valid;
        exp_valid = !m_inflight ? 2'b00 : ((m_grant == 0) ? 2'b10 : 2'b01);
        check("req_ready0", 64'(req_ready[0]), 64'(mq0.size() < DEPTH));
        check("req_ready1", 64'(req_ready[1]), 64'(mq1.size() < DEPTH));
        check("pending0", 64'(pending[0]), 64'(mq0.size()));
        check("pending1", 64'(pending[1]), 64'(mq1.size()));
        check("inv_valid", 64'(inv_valid), 64'(exp_valid));
        check("busy", 64'(busy), 64'(m_inflight || mq0.size() > 0 || mq1.size() > 0));
        if (m_inflight) check("inv_addr", 64'(inv_addr), 64'(m_inv_addr));
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] ack);
        req_valid   = v;
        req_addr[0] = a0;
        req_addr[1] = a1;
        inv_ack     = ack;
        n_steps++;
        $display("step %0d valid=%b a0=%h a1=%h ack=%b", n_steps, v, a0, a1, ack);
        model_update(v, a0, a1, ack);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        inv_ack   = '0;
        $display("reset pulse");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        compare_all();
        check("rst_inv_valid", 64'(inv_valid), 64'(2'b00));
        check("rst_inv_addr", 64'(inv_addr), 64'(0));
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(2'b11));
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single request
        step(2'b01, 32'h0000_1234, 32'h0, 2'b00);
        step(2'b00, 32'h0, 32'h0, 2'b00);
        check("single_valid", 64'(inv_valid), 64'(2'b10));
        check("single_addr", 64'(inv_addr), 64'(32'h0000_1230));
        step(2'b00, 32'h0, 32'h0, 2'b10);
        check("single_busy", 64'(busy), 64'(0));

        // Tie after reset, then a refill
        do_reset();
        for (int r = 0; r < 2; r++) begin
            step(2'b11, 32'h100, 32'h200, 2'b00);
            step(2'b00, 32'h0, 32'h0, 2'b00);
            check("tie_first_valid", 64'(inv_valid), 64'(2'b10));
            check("tie_first_addr", 64'(inv_addr), 64'(32'h100));
            step(2'b00, 32'h0, 32'h0, 2'b10);
            step(2'b00, 32'h0, 32'h0, 2'b00);
            check("tie_second_valid", 64'(inv_valid), 64'(2'b01));
            check("tie_second_addr", 64'(inv_addr), 64'(32'h200));
            step(2'b00, 32'h0, 32'h0, 2'b01);
        end

        // Coalescing on core1
        step(2'b10, 32'h0, 32'h40, 2'b00);
        step(2'b10, 32'h0, 32'h44, 2'b00);
        step(2'b10, 32'h0, 32'h48, 2'b00);
        check("coal_pending1", 64'(pending[1]), 64'(1));
        check("coal_addr", 64'(inv_addr), 64'(32'h40));
        step(2'b00, 32'h0, 32'h0, 2'b01);
        step(2'b00, 32'h0, 32'h0, 2'b00);
        check("coal_no_second", 64'(inv_valid), 64'(2'b00));

        // Fill core0 queue
        step(2'b01, 32'h1000, 32'h0, 2'b00);
        step(2'b01, 32'h2000, 32'h0, 2'b00);
        step(2'b01, 32'h3000, 32'h0, 2'b00);
        step(2'b01, 32'h4000, 32'h0, 2'b00);
        check("full_ready0", 64'(req_ready[0]), 64'(0));
        check("full_pending0", 64'(pending[0]), 64'(4));
        step(2'b01, 32'h5000, 32'h0, 2'b00);
        check("full_reject", 64'(pending[0]), 64'(4));
        step(2'b00, 32'h0, 32'h0, 2'b10);
        check("full_ready_after_ack", 64'(req_ready[0]), 64'(1));

        // Long stall, then reset in the middle of it
        step(2'b00, 32'h0, 32'h0, 2'b00);
        for (int k = 0; k < 20; k++) begin
            step(2'b00, 32'h0, 32'h0, 2'b01);
            check("stall_valid", 64'(inv_valid), 64'(2'b10));
            check("stall_addr", 64'(inv_addr), 64'(32'h2000));
        end
        do_reset();

        // Random traffic over a small line pool so coalescing and full queues occur
        for (int n = 0; n < 800; n++) begin
            logic [1:0]  v;
            logic [1:0]  ack;
            logic [31:0] a0;
            logic [31:0] a1;
            v   = 2'($urandom);
            ack = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            a0  = 32'hA000_0000 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 15));
            a1  = 32'hA000_0000 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) do_reset();
            else step(v, a0, a1, ack);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
